data_request_engine: RTL
========================

DATA_REQUEST_ENGINE -- requirements
Module: data_request_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of source data and FIFO words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-cycle limit for the watchdog.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req_word  input  32  command word from request output register: [31] start toggle, [23:16] channel, [15:0] word count.
REQ-007 src_req  output  1  one-cycle pulse starting a transfer at the source.
REQ-008 src_chan  output  8  channel of the current transfer, held from src_req until next command.
REQ-009 src_valid  input  1  source data valid.
REQ-010 src_data  input  DATA_W  source data word.
REQ-011 src_ready  output  1  engine accepts src_data this cycle.
REQ-012 rd_strobe  input  1  one-cycle pop request from CPU-side read register.
REQ-013 rd_data  output  DATA_W  FIFO head word.
REQ-014 status  output  32  [0] busy, [1] done, [2] cmd_err, [3] underflow, [4] timeout, [14:8] fifo level, [31:16] words received.

Function
REQ-015 SHALL register req_word[31] and detect a command on any change (0->1 or 1->0) versus the registered value.
REQ-016 SHALL implement states IDLE, ISSUE, COLLECT, DONE; DONE behaves as IDLE for command acceptance.
REQ-017 IDLE/DONE + command: latch channel and count, clear done/cmd_err/underflow/timeout and words received, go ISSUE next cycle.
REQ-018 ISSUE: assert src_req for exactly one cycle; go COLLECT if count>0, else DONE.
REQ-019 COLLECT: src_ready = FIFO not full; a transfer occurs when src_valid && src_ready; each transfer pushes src_data and increments words received.
REQ-020 COLLECT -> DONE in the cycle after the transfer that makes words received equal count; src_ready low outside COLLECT.
REQ-021 Command detected while in ISSUE or COLLECT SHALL be ignored and set sticky cmd_err; the toggle register still updates.
REQ-022 busy = state is ISSUE or COLLECT; done set on entry to DONE, held until next accepted command.
REQ-023 FIFO: rd_data shows head combinationally from storage; rd_strobe on non-empty pops one word, level updates next cycle.
REQ-024 rd_strobe on empty SHALL not change pointers and SHALL set sticky underflow.
REQ-025 Simultaneous push and pop on non-empty FIFO: level unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-026 Words left in FIFO at a new command SHALL be retained (FIFO not flushed).
REQ-027 Count field treated unsigned; words received counter 16 bits, never exceeds count.

Reset
REQ-028 Reset assertion SHALL asynchronously force state IDLE, FIFO empty, all counters and sticky bits 0, src_req 0, src_chan 0, src_ready 0, rd_data 0 contents irrelevant but status 0.
REQ-029 Toggle register SHALL reset to 0; if req_word[31]=1 at reset release a command is detected on the first clock.
REQ-030 Reset mid-COLLECT SHALL abandon the transfer with no further src_ready.

Configuration
REQ-031 Macro DATA_REQUEST_TIMEOUT_EN defined: counter clears on each transfer and on COLLECT entry, increments each COLLECT cycle without transfer; reaching TIMEOUT_CYCLES sets timeout and goes DONE.
REQ-032 Macro undefined: no watchdog logic, status[4] constant 0, COLLECT waits indefinitely.

Verification
REQ-033 Reset, req_word=0x8005_0003, source streams 3 words 0xA1,0xA2,0xA3 -> one src_req pulse, src_chan=0x05, status done=1, level=3, words=3.
REQ-034 20-word command with FIFO_DEPTH=16 and no reads -> src_ready drops at level 16; after 4 rd_strobe, remaining 4 words accepted, done=1.
REQ-035 Toggle bit31 again during COLLECT -> cmd_err=1, transfer completes unchanged, next toggle in DONE clears cmd_err.
REQ-036 Command with count=0 -> src_req pulse, DONE two cycles after detection, src_ready never high.
REQ-037 rd_strobe on empty FIFO -> underflow=1, level stays 0; push+pop same cycle at level 5 -> level 5.
REQ-038 With DATA_REQUEST_TIMEOUT_EN, TIMEOUT_CYCLES=1024, source stalls after 2 of 8 words -> timeout=1, done=1, words=2 after 1024 idle cycles.

Source files
------------

// File: rtl/data_request_if.sv
// data_request_if: command, source stream and CPU read-side signals of the data request engine.
interface data_request_if #(
    parameter int DATA_W = 16
) ();
    logic [31:0]       req_word;
    logic              src_req;
    logic [7:0]        src_chan;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              rd_strobe;
    logic [DATA_W-1:0] rd_data;
    logic [31:0]       status;

    modport master (
        input  req_word, src_valid, src_data, rd_strobe,
        output src_req, src_chan, src_ready, rd_data, status
    );

    modport slave (
        output req_word, src_valid, src_data, rd_strobe,
        input  src_req, src_chan, src_ready, rd_data, status
    );
endinterface

// File: rtl/data_request_engine.sv
// data_request_engine: toggle-triggered source request engine collecting words into a read FIFO.
// Define DATA_REQUEST_TIMEOUT_EN to add the idle watchdog on COLLECT.
module data_request_engine #(
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic            clk,
    input logic            reset_n,
    data_request_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} state_t;

    state_t            state, state_n;
    logic              tog;
    logic [7:0]        chan;
    logic [15:0]       count, words;
    logic              cmd_err, underflow, timeout;
    logic [AW:0]       wr_ptr, rd_ptr, level;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              cmd, accept, full, empty, push, pop, tmo_hit;
    logic              unused_bits;

    assign cmd         = bus.req_word[31] ^ tog;
    assign accept      = cmd && (state == IDLE || state == DONE);
    assign level       = wr_ptr - rd_ptr;
    assign full        = level[AW];
    assign empty       = level == '0;
    assign push        = bus.src_ready && bus.src_valid;
    assign pop         = bus.rd_strobe && !empty;
    assign unused_bits = ^bus.req_word[30:24];

    assign bus.src_req   = state == ISSUE;
    assign bus.src_ready = state == COLLECT && !full;
    assign bus.src_chan  = chan;
    assign bus.rd_data   = mem[rd_ptr[AW-1:0]];
    assign bus.status    = {words, 1'b0, 7'(level), 3'b000, timeout, underflow, cmd_err,
                            state == DONE, state == ISSUE || state == COLLECT};

`ifdef DATA_REQUEST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = 1;
    logic [TW-1:0] idle_cnt;

    // Counter is held at zero outside COLLECT, so COLLECT entry always starts from zero.
    assign tmo_hit = state == COLLECT && !push && idle_cnt == TMO_LAST;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) idle_cnt <= '0;
        else idle_cnt <= (state != COLLECT || push) ? '0 : idle_cnt + TMO_ONE;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: state_n = accept ? ISSUE : state;
            ISSUE:      state_n = count == '0 ? DONE : COLLECT;
            COLLECT:    state_n = ((push && words + 16'd1 == count) || tmo_hit) ? DONE : COLLECT;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tog       <= 1'b0;
            chan      <= '0;
            count     <= '0;
            words     <= '0;
            cmd_err   <= 1'b0;
            underflow <= 1'b0;
            timeout   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_n;
            tog       <= bus.req_word[31];
            chan      <= accept ? bus.req_word[23:16] : chan;
            count     <= accept ? bus.req_word[15:0] : count;
            words     <= accept ? '0 : push ? words + 16'd1 : words;
            cmd_err   <= !accept && (cmd_err || cmd);
            underflow <= (underflow && !accept) || (bus.rd_strobe && empty);
            timeout   <= (timeout && !accept) || tmo_hit;
            wr_ptr    <= push ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + PTR_ONE : rd_ptr;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= bus.src_data;
endmodule
